// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DRAIN
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: one memory read per PC value, holds the result for decode,
// forwards execute redirects to the PC and discards fetches made stale by them.
//
// state | meaning
// IDLE  | just out of reset, nothing issued yet
// REQ   | read request presented at pcValue
// WAIT  | request accepted, waiting for the response
// HOLD  | instruction held for decode
// DRAIN | stale request in flight, response will be dropped
module instruction_fetch_unit
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pcValue,
  output logic [XLEN-1:0] pcDataIn,
  output logic            pcWriteEnable,
  output logic            pcWriteAdd,
  output logic            pcCountEnable,
  output logic            memReqValid,
  input  logic            memReqReady,
  output logic [XLEN-1:0] memReqAddr,
  input  logic            memRspValid,
  input  logic [XLEN-1:0] memRspData,
  output logic            instValid,
  input  logic            instReady,
  output logic [XLEN-1:0] instData,
  output logic [XLEN-1:0] instAddr,
  input  logic            redirectValid,
  input  logic            redirectRelative,
  input  logic [XLEN-1:0] redirectTarget
);

  fetch_state_t    state;
  fetch_state_t    state_next;
  logic [XLEN-1:0] inst_data_q;
  logic [XLEN-1:0] inst_addr_q;
  logic            req_fire;
  logic            capture;
  logic            redirect;

  // Redirect strobes are gated by reset so every output reads 0 while held in reset.
  assign redirect = redirectValid & reset;
  assign req_fire = (state == REQ) & memReqReady;
  assign capture  = (state == WAIT) & memRspValid & ~redirectValid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      inst_data_q <= '0;
      inst_addr_q <= '0;
    end else begin
      state <= state_next;
      if (req_fire) inst_addr_q <= pcValue;
      if (capture)  inst_data_q <= memRspData;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: state_next = REQ;
      REQ: begin
        if (memReqReady) state_next = redirectValid ? DRAIN : WAIT;
      end
      WAIT: begin
        if (redirectValid)    state_next = memRspValid ? REQ : DRAIN;
        else if (memRspValid) state_next = HOLD;
      end
      HOLD: begin
        if (redirectValid || instReady) state_next = REQ;
      end
      DRAIN: begin
        if (memRspValid) state_next = REQ;
      end
      default: state_next = IDLE;
    endcase
  end

  assign memReqValid   = (state == REQ);
  assign memReqAddr    = (state == REQ) ? pcValue : '0;
  assign pcCountEnable = req_fire & ~redirectValid;
  assign pcWriteEnable = redirect;
  assign pcWriteAdd    = redirect & redirectRelative;
  assign pcDataIn      = redirect ? redirectTarget : '0;
  assign instValid     = (state == HOLD);
  assign instData      = inst_data_q;
  assign instAddr      = inst_addr_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios followed by random traffic,
// checked against a PC/memory/instruction-stream model kept in the bench.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pcValue;
  logic [31:0] pcDataIn;
  logic        pcWriteEnable;
  logic        pcWriteAdd;
  logic        pcCountEnable;
  logic        memReqValid;
  logic        memReqReady;
  logic [31:0] memReqAddr;
  logic        memRspValid;
  logic [31:0] memRspData;
  logic        instValid;
  logic        instReady;
  logic [31:0] instData;
  logic [31:0] instAddr;
  logic        redirectValid;
  logic        redirectRelative;
  logic [31:0] redirectTarget;

  instruction_fetch_unit dut (
    .clk(clk), .reset(reset), .pcValue(pcValue), .pcDataIn(pcDataIn),
    .pcWriteEnable(pcWriteEnable), .pcWriteAdd(pcWriteAdd), .pcCountEnable(pcCountEnable),
    .memReqValid(memReqValid), .memReqReady(memReqReady), .memReqAddr(memReqAddr),
    .memRspValid(memRspValid), .memRspData(memRspData), .instValid(instValid),
    .instReady(instReady), .instData(instData), .instAddr(instAddr),
    .redirectValid(redirectValid), .redirectRelative(redirectRelative),
    .redirectTarget(redirectTarget)
  );

  always #5 clk = ~clk;

  int          n_asserts = 0;
  int          n_fails = 0;
  int          n_count = 0;
  int          delivered = 0;
  logic [31:0] pc;
  logic [31:0] next_fetch;
  logic [31:0] exp_q[$];
  bit          rsp_pending;
  logic [31:0] rsp_addr;
  int          rsp_delay;
  bit          pc_we, pc_add, pc_cnt, last_hs;
  logic [31:0] pc_din;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h00500093;
    return (a * 32'h9E3779B1) ^ 32'h00000013;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pc = '0; next_fetch = '0; exp_q.delete();
    rsp_pending = 0; rsp_delay = 0; rsp_addr = '0;
    pc_we = 0; pc_add = 0; pc_cnt = 0; pc_din = '0; last_hs = 0;
    pcValue = '0; memReqReady = 0; memRspValid = 0; memRspData = '0;
    instReady = 0; redirectValid = 0; redirectRelative = 0; redirectTarget = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pcDataIn"}, pcDataIn, 32'h0);
    check1({tag, "_pcWriteEnable"}, pcWriteEnable, 1'b0);
    check1({tag, "_pcWriteAdd"}, pcWriteAdd, 1'b0);
    check1({tag, "_pcCountEnable"}, pcCountEnable, 1'b0);
    check1({tag, "_memReqValid"}, memReqValid, 1'b0);
    check({tag, "_memReqAddr"}, memReqAddr, 32'h0);
    check1({tag, "_instValid"}, instValid, 1'b0);
    check({tag, "_instData"}, instData, 32'h0);
    check({tag, "_instAddr"}, instAddr, 32'h0);
  endtask

  // Compare one cycle of DUT outputs against the model, then advance the model.
  task automatic observe(input int lat);
    bit hs;
    hs = memReqValid && memReqReady;
    last_hs = hs;
    if (rsp_pending || exp_q.size() != 0) check1("req_blocked", memReqValid, 1'b0);
    if (instValid) begin
      if (exp_q.size() == 0) check1("stale_inst", instValid, 1'b0);
      else begin
        check("inst_addr", instAddr, exp_q[0]);
        check("inst_data", instData, mem_word(exp_q[0]));
        if (instReady) begin
          void'(exp_q.pop_front());
          delivered++;
        end
      end
    end
    if (redirectValid) begin
      check1("pc_we", pcWriteEnable, 1'b1);
      check1("pc_add", pcWriteAdd, redirectRelative);
      check("pc_din", pcDataIn, redirectTarget);
    end else begin
      check1("pc_we_quiet", pcWriteEnable, 1'b0);
      check("pc_din_quiet", pcDataIn, 32'h0);
    end
    check1("pc_count", pcCountEnable, hs && !redirectValid);
    if (pcCountEnable) n_count++;
    if (hs) begin
      check("req_addr", memReqAddr, next_fetch);
      check1("one_outstanding", rsp_pending, 1'b0);
      rsp_pending = 1; rsp_addr = memReqAddr; rsp_delay = lat;
      if (!redirectValid) begin
        exp_q.push_back(next_fetch);
        next_fetch = next_fetch + 32'd4;
      end
    end
    if (redirectValid) begin
      exp_q.delete();
      next_fetch = redirectRelative ? next_fetch + redirectTarget - 32'd4 : redirectTarget;
    end
    pc_we = pcWriteEnable; pc_add = pcWriteAdd; pc_din = pcDataIn; pc_cnt = pcCountEnable;
  endtask

  task automatic step(input bit rdy, input bit irdy, input bit rv, input bit rrel,
                      input logic [31:0] rtgt, input int lat);
    @(negedge clk);
    if (pc_we) pc = pc_add ? pc + pc_din - 32'd4 : pc_din;
    else if (pc_cnt) pc = pc + 32'd4;
    pcValue = pc;
    memRspValid = 0; memRspData = '0;
    if (rsp_pending) begin
      rsp_delay--;
      if (rsp_delay <= 0) begin
        memRspValid = 1; memRspData = mem_word(rsp_addr); rsp_pending = 0;
      end
    end
    memReqReady = rdy; instReady = irdy;
    redirectValid = rv; redirectRelative = rrel; redirectTarget = rtgt;
    #1;
    observe(lat);
  endtask

  task automatic run_to_hold(input int lat);
    for (int i = 0; i < 20; i++) begin
      if (instValid) break;
      step(1, 0, 0, 0, 32'h0, lat);
    end
    check1("reach_hold", instValid, 1'b1);
  endtask

  task automatic run_to_req_fire(input int lat);
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 0, 0, 32'h0, lat);
      if (last_hs) break;
    end
    check1("reach_req", last_hs, 1'b1);
  endtask

  initial begin
    int saved_n, saved_del;
    logic [31:0] off;
    reset = 1'b0;
    model_reset();
    #2;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // First fetch from 0
    run_to_hold(1);
    check("t1_data", instData, 32'h00500093);
    check("t1_addr", instAddr, 32'h0);
    check("t1_count", n_count, 32'd1);

    // Decode backpressure
    repeat (5) step(1, 0, 0, 0, 32'h0, 1);
    check1("bp_valid", instValid, 1'b1);
    check("bp_data", instData, 32'h00500093);
    check("bp_count", n_count, 32'd1);
    run_to_req_fire(1);
    check("t1_next_addr", memReqAddr, 32'h4);

    // Relative redirect from HOLD at 0x10
    run_to_hold(1);
    for (int k = 0; k < 3; k++) begin
      run_to_req_fire(1);
      run_to_hold(1);
    end
    check("hold_addr", instAddr, 32'h10);
    check("hold_pc", pcValue, 32'h14);
    step(1, 0, 1, 1, 32'hFFFFFFF8, 1);
    check1("rd_hold_we", pcWriteEnable, 1'b1);
    check1("rd_hold_add", pcWriteAdd, 1'b1);
    check("rd_hold_din", pcDataIn, 32'hFFFFFFF8);
    step(1, 1, 0, 0, 32'h0, 1);
    check1("rd_hold_drop", instValid, 1'b0);
    check1("rd_hold_hs", last_hs, 1'b1);
    check("rd_hold_addr", memReqAddr, 32'h8);

    // Absolute redirect while waiting, response arrives later
    run_to_hold(1);
    run_to_req_fire(4);
    step(1, 1, 1, 0, 32'h100, 1);
    saved_del = delivered;
    run_to_req_fire(1);
    check("rd_wait_addr", memReqAddr, 32'h100);
    check("rd_wait_nodeliver", delivered, saved_del);

    // Redirect on the same cycle as a request handshake
    run_to_hold(1);
    step(1, 1, 0, 0, 32'h0, 1);
    saved_n = n_count;
    step(1, 1, 1, 0, 32'h200, 2);
    check1("rd_hs_fire", last_hs, 1'b1);
    check1("rd_hs_nocount", pcCountEnable, 1'b0);
    check("rd_hs_count", n_count, saved_n);
    saved_del = delivered;
    run_to_req_fire(3);
    check("rd_hs_addr", memReqAddr, 32'h200);
    check("rd_hs_nodeliver", delivered, saved_del);

    // Asynchronous reset while waiting for a response
    step(1, 1, 0, 0, 32'h0, 1);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    run_to_hold(1);
    check("rst_restart_addr", instAddr, 32'h0);
    check("rst_restart_data", instData, 32'h00500093);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      bit rv, rrel;
      rv   = ($urandom_range(0, 99) < 8);
      rrel = $urandom_range(0, 1) == 1;
      off  = rrel ? (32'($urandom_range(0, 32)) * 32'd4 - 32'd64) : ($urandom() & 32'hFFFFFFFC);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 6, rv, rrel, off,
           int'($urandom_range(1, 3)));
    end
    check1("progress", delivered > 40, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
